// File: rtl/redmule_w_row_packer_if.sv
// Beat stream and row-write bus around the W row packer. The master side is the surrounding datapath
// (streamer plus W buffer); the slave side is the packer itself.
interface redmule_w_row_packer_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned ELMS       = 2,
    parameter int unsigned BEAT_WORDS = 4
);
    logic                                        in_valid_i;
    logic                                        in_ready_o;
    logic [BEAT_WORDS*WORD_SIZE-1:0]             in_data_i;
    logic                                        wr_ready_i;
    logic                                        write_en_o;
    logic [$clog2(ROWS)-1:0]                     write_addr_o;
    logic [COLS-1:0][ELMS-1:0][WORD_SIZE-1:0]    wdata_o;

    modport master (
        output in_valid_i, in_data_i, wr_ready_i,
        input  in_ready_o, write_en_o, write_addr_o, wdata_o
    );

    modport slave (
        input  in_valid_i, in_data_i, wr_ready_i,
        output in_ready_o, write_en_o, write_addr_o, wdata_o
    );
endinterface

// File: rtl/redmule_w_row_packer.sv
// Packs W beats into COLS*ELMS-word rows and writes them to the W buffer (REDMULE_W_PACKER_PERF_EN adds a stall counter).
// Latency: a row write can fire the cycle after the last beat of that row is accepted.
// Backpressure: in_ready drops for the WRITE cycle(s); wr_ready low holds address and data indefinitely.
module redmule_w_row_packer #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned ELMS       = 2,
    parameter int unsigned BEAT_WORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [$clog2(ROWS):0]   n_rows_i,
    input  logic [$clog2(ROWS)-1:0] base_addr_i,
    redmule_w_row_packer_if.slave   bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [15:0]             stall_cnt_o
);

    localparam int unsigned AW        = $clog2(ROWS);
    localparam int unsigned RW        = AW + 1;
    localparam int unsigned ROW_WORDS = COLS * ELMS;
    localparam int unsigned BPR       = ROW_WORDS / BEAT_WORDS;
    localparam int unsigned BCW       = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int unsigned BEAT_BITS = BEAT_WORDS * WORD_SIZE;

    if ((ROW_WORDS % BEAT_WORDS) != 0) begin : g_bad_beat_cfg
        $error("COLS*ELMS must be a multiple of BEAT_WORDS");
    end
    if ((ROWS < 2) || ((ROWS & (ROWS - 1)) != 0)) begin : g_bad_rows_cfg
        $error("ROWS must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [BCW-1:0]                beat_cnt_q;
    logic [RW-1:0]                 row_cnt_q;
    logic [RW-1:0]                 n_rows_q;
    logic [AW-1:0]                 base_q;
    logic [BPR-1:0][BEAT_BITS-1:0] pack_q;

    logic in_ready;
    logic write_en;
    logic done;
    logic accept;
    logic last_beat;
    logic last_row;

    assign last_beat = (beat_cnt_q == BCW'(BPR - 1));
    assign last_row  = ((row_cnt_q + RW'(1)) == n_rows_q);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        write_en = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (n_rows_i == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                in_ready = 1'b1;
                if (bus.in_valid_i && last_beat) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                write_en = bus.wr_ready_i;
                if (bus.wr_ready_i) begin
                    state_d = last_row ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Soft clear wins over every handshake in the same cycle.
        if (clear_i) begin
            state_d  = ST_IDLE;
            in_ready = 1'b0;
            write_en = 1'b0;
            done     = 1'b0;
        end
    end

    assign accept = in_ready & bus.in_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            n_rows_q   <= '0;
            base_q     <= '0;
            pack_q     <= '0;
        end else begin
            state_q <= state_d;
            if (clear_i) begin
                // Partial rows are dropped; pack_q keeps its stale contents on purpose.
                beat_cnt_q <= '0;
                row_cnt_q  <= '0;
            end else begin
                if ((state_q == ST_IDLE) && start_i && (n_rows_i != '0)) begin
                    n_rows_q   <= n_rows_i;
                    base_q     <= base_addr_i;
                    beat_cnt_q <= '0;
                    row_cnt_q  <= '0;
                end
                if (accept) begin
                    pack_q[beat_cnt_q] <= bus.in_data_i;
                    beat_cnt_q         <= last_beat ? '0 : beat_cnt_q + BCW'(1);
                end
                if (write_en) begin
                    row_cnt_q <= row_cnt_q + RW'(1);
                end
            end
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.write_en_o   = write_en;
    assign bus.write_addr_o = base_q + row_cnt_q[AW-1:0];
    assign bus.wdata_o      = pack_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done;

`ifdef REDMULE_W_PACKER_PERF_EN
    logic [15:0] stall_cnt_q;
    logic        stall_evt;

    assign stall_evt = ((state_q == ST_FILL) && !bus.in_valid_i) ||
                       ((state_q == ST_WRITE) && !bus.wr_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i || ((state_q == ST_IDLE) && start_i)) begin
            stall_cnt_q <= '0;
        end else if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/redmule_w_row_packer.md
Name: redmule_w_row_packer

Overview:
- Write-side feeder for the W row buffer; sits directly upstream of it.
- Accepts a valid/ready stream of W beats from the streamer and packs them into full rows of COLS×ELMS words.
- Issues one row write per packed row: write enable, row address and row data.
- Tracks a programmable row count with wrap-around addressing and signals completion to the controller.

Parameters:
- WORD_SIZE, 32, bits per element word.
- ROWS, 4, rows in the target buffer; power of two, ≥2.
- COLS, 4, columns per row.
- ELMS, 2, elements per column.
- BEAT_WORDS, 4, words per input beat; COLS×ELMS must be a multiple of BEAT_WORDS (elaboration-time check).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  start pulse; sampled in IDLE only.
- n_rows_i  in  $clog2(ROWS)+1  rows to load (0..ROWS); sampled on start.
- base_addr_i  in  $clog2(ROWS)  first row address; sampled on start.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat ready.
- in_data_i  in  BEAT_WORDS×WORD_SIZE  beat data; word k at bits [k×WORD_SIZE +: WORD_SIZE].
- wr_ready_i  in  1  buffer may accept a row write this cycle.
- write_en_o  out  1  row write strobe to the buffer.
- write_addr_o  out  $clog2(ROWS)  row address.
- wdata_o  out  COLS×ELMS×WORD_SIZE  packed row, [COLS][ELMS][WORD_SIZE].
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- stall_cnt_o  out  16  stall counter (see Optional Feature).

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; beat, row and stall counters 0; pack register 0; all outputs 0.
- Constants: BPR (beats per row) = COLS×ELMS/BEAT_WORDS.
- Packing map: beat b, word k → flat index f = b×BEAT_WORDS+k → column f/ELMS, element f%ELMS.
- IDLE:
  - in_ready_o=0, write_en_o=0.
  - start_i with n_rows_i>0: latch n_rows and base address, clear the counters, go to FILL.
  - start_i with n_rows_i=0: go to DONE, no writes.
- FILL:
  - in_ready_o=1.
  - Accept a beat (in_valid_i & in_ready_o): store it at beat_cnt and increment beat_cnt.
  - Accepting beat BPR-1: reset beat_cnt to 0, go to WRITE next cycle.
- WRITE:
  - in_ready_o=0; wdata_o holds the packed row stable.
  - write_en_o = wr_ready_i, combinational; exactly one write per row.
  - When a write occurs, row_cnt increments. If the new row_cnt equals n_rows go to DONE, else go to FILL.
- write_addr_o:
  - Value is (base + row_cnt) mod ROWS.
  - Wraps from ROWS-1 to 0.
  - Valid whenever write_en_o is high.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: the row write can occur at the earliest 1 cycle after the last beat of that row is accepted.
- Back-to-back input: at most 1 bubble per row, during the WRITE cycle.
- start_i while busy: ignored.
- clear_i: has priority over everything except rst_i.
  - Same cycle: force write_en_o=0 and in_ready_o=0.
  - Next cycle: IDLE, counters 0, pack register keeps its contents, no done_o.
- Reset or clear mid-row: partial beats are discarded and no write is issued.
- Stall in WRITE (wr_ready_i=0): state, address and data held indefinitely.

Optional Feature:
- Macro: REDMULE_W_PACKER_PERF_EN.
- Defined:
  - stall_cnt_o counts cycles spent in FILL with in_valid_i=0, plus cycles in WRITE with wr_ready_i=0.
  - Saturates at 0xFFFF; cleared on start, clear_i and reset.
- Undefined: stall_cnt_o tied to 0 and the counter logic is absent.

Test Plan (defaults; 8 words/row, BPR=2):
- Single row: start, n_rows=1, base=0; beats words 0..3 then 4..7, back-to-back, wr_ready=1.
  - in_ready high 2 cycles; write_en 1 cycle later.
  - addr=0; wdata[c][e]=2c+e.
  - done pulse next cycle, then IDLE.
- Wrap-around: n_rows=4, base=2, continuous input.
  - Write addresses 2,3,0,1.
  - Exactly 4 write strobes; one bubble per row on in_ready; done after the 4th write.
- Write backpressure: hold wr_ready=0 for 5 cycles in WRITE.
  - write_en=0, in_ready=0, addr/data stable.
  - Write fires on the cycle wr_ready returns to 1.
  - With PERF_EN: stall_cnt=5.
- Input gaps: in_valid toggled 1,0,0,1.
  - Row still packed in order; no write before the 2nd beat is accepted.
  - With PERF_EN: stall_cnt=2.
- Clear mid-row: clear_i after 1 beat of row 2 of n_rows=3.
  - No further writes, no done_o, IDLE next cycle.
  - A new start with n_rows=1, base=1 writes addr 1 correctly.
- Edge cases:
  - n_rows=0: done 1 cycle after start with no writes.
  - start_i pulsed during FILL: ignored.
  - rst_i mid-WRITE: all outputs 0 the next cycle.
